// File: rtl/fft_ctrl_pkg.sv
// rtl/fft_ctrl_pkg.sv - shared FSM encoding and size helpers for the FFT stage sequencer
package fft_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FIN   = 2'd3
   } fft_state_t;

   // Transform length for a given log2 size
   function automatic int fft_n(input int n_log2);
      return 1 << n_log2;
   endfunction

   // Butterflies per stage
   function automatic int fft_half_n(input int n_log2);
      return fft_n(n_log2) / 2;
   endfunction

   // Drain counter must hold 1+latency
   function automatic int cnt_width(input int bf_latency);
      return $clog2(bf_latency + 2);
   endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// rtl/fft_addr_gen.sv - maps (stage, butterfly index) to radix-2 DIT pair and twiddle addresses
module fft_addr_gen #(
   parameter int N_LOG2 = 4
) (
   input  logic [N_LOG2-1:0] stage_i,
   input  logic [N_LOG2-2:0] k_i,
   output logic [N_LOG2-1:0] a_o,
   output logic [N_LOG2-1:0] b_o,
   output logic [N_LOG2-2:0] tw_o
);

   localparam int              LAST_I = N_LOG2 - 1;
   localparam logic [N_LOG2-1:0] LAST_S = LAST_I[N_LOG2-1:0];
   localparam logic [N_LOG2-1:0] ONE    = N_LOG2'(1);

   logic [N_LOG2-1:0] kx;
   logic [N_LOG2-1:0] span;
   logic [N_LOG2-1:0] pos;
   logic [N_LOG2-1:0] grp;
   logic [N_LOG2-1:0] a;

   // Group/position split of k; the lower leg sits one span above the upper leg
   always_comb begin
      kx   = {1'b0, k_i};
      span = ONE << stage_i;
      pos  = kx & (span - ONE);
      grp  = kx >> stage_i;
      a    = ((grp << stage_i) << 1) | pos;
      a_o  = a;
      b_o  = a | span;
      tw_o = (N_LOG2-1)'(pos << (LAST_S - stage_i));
   end

endmodule

// File: rtl/fft_stage_sched.sv
// rtl/fft_stage_sched.sv - in-place radix-2 FFT stage sequencer with write-back delay line
module fft_stage_sched #(
   parameter int N_LOG2     = 4,
   parameter int BF_LATENCY = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              inv_i,
   input  logic              hold_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [N_LOG2-1:0] stage_o,
   output logic              rd_en_o,
   output logic [N_LOG2-1:0] rd_addr_a_o,
   output logic [N_LOG2-1:0] rd_addr_b_o,
   output logic [N_LOG2-2:0] tw_addr_o,
   output logic              tw_conj_o,
   output logic              wr_en_o,
   output logic [N_LOG2-1:0] wr_addr_a_o,
   output logic [N_LOG2-1:0] wr_addr_b_o
);

   import fft_ctrl_pkg::*;

   localparam int K_W    = N_LOG2 - 1;
   localparam int HALF_N = fft_half_n(N_LOG2);
   localparam int DEPTH  = 1 + BF_LATENCY;
   localparam int CNT_W  = cnt_width(BF_LATENCY);
   localparam int DLY_W  = 1 + 2 * N_LOG2;

   localparam int                K_LAST_I = HALF_N - 1;
   localparam logic [K_W-1:0]    K_LAST   = K_LAST_I[K_W-1:0];
   localparam int                S_LAST_I = N_LOG2 - 1;
   localparam logic [N_LOG2-1:0] S_LAST   = S_LAST_I[N_LOG2-1:0];
   localparam logic [CNT_W-1:0]  CNT_INIT = DEPTH[CNT_W-1:0];

   fft_state_t        state_q, state_d;
   logic [N_LOG2-1:0] stage_q, stage_d;
   logic [K_W-1:0]    k_q, k_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              inv_q, inv_d;
   logic              issue;

   logic [N_LOG2-1:0] gen_a, gen_b;
   logic [N_LOG2-2:0] gen_tw;

   logic [DEPTH-1:0][DLY_W-1:0] dly_q;

   fft_addr_gen #(
      .N_LOG2 (N_LOG2)
   ) u_addr_gen (
      .stage_i (stage_q),
      .k_i     (k_q),
      .a_o     (gen_a),
      .b_o     (gen_b),
      .tw_o    (gen_tw)
   );

   // Control state register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         stage_q <= '0;
         k_q     <= '0;
         cnt_q   <= '0;
         inv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         k_q     <= k_d;
         cnt_q   <= cnt_d;
         inv_q   <= inv_d;
      end
   end

   // Next-state: issue N/2 pairs per stage, then drain until the last write has landed
   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      k_d     = k_q;
      cnt_d   = cnt_q;
      inv_d   = inv_q;
      issue   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               inv_d   = inv_i;
               stage_d = '0;
               k_d     = '0;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (!hold_i) begin
               issue = 1'b1;
               if (k_q == K_LAST) begin
                  cnt_d   = CNT_INIT;
                  state_d = ST_DRAIN;
               end else begin
                  k_d = k_q + 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               if (stage_q == S_LAST) begin
                  state_d = ST_FIN;
               end else begin
                  stage_d = stage_q + 1'b1;
                  k_d     = '0;
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Read-side addresses are forced to zero when no pair is issued
   assign rd_en_o     = issue;
   assign rd_addr_a_o = issue ? gen_a : '0;
   assign rd_addr_b_o = issue ? gen_b : '0;
   assign tw_addr_o   = issue ? gen_tw : '0;
   assign tw_conj_o   = inv_q & (state_q != ST_IDLE);
   assign busy_o      = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
   assign done_o      = (state_q == ST_FIN);
   assign stage_o     = stage_q;

   // Write-back delay line: free-running, so hold bubbles reappear as wr_en gaps
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         dly_q <= '0;
      end else begin
         dly_q <= {dly_q[DEPTH-2:0], {issue, rd_addr_a_o, rd_addr_b_o}};
      end
   end

   assign {wr_en_o, wr_addr_a_o, wr_addr_b_o} = dly_q[DEPTH-1];

endmodule

// File: tb/tb_fft_stage_sched.sv
// tb/tb_fft_stage_sched.sv - self-checking bench for fft_stage_sched against a schedule model
module tb_fft_stage_sched;

   localparam int NL   = 4;
   localparam int BF   = 2;
   localparam int D    = BF + 1;
   localparam int HALF = (1 << NL) / 2;
   localparam int MAXC = 200;

   logic clk = 1'b0;
   logic rst, start, inv, hold;
   logic busy_o, done_o, rd_en_o, tw_conj_o, wr_en_o;
   logic [NL-1:0] stage_o, rd_addr_a_o, rd_addr_b_o, wr_addr_a_o, wr_addr_b_o;
   logic [NL-2:0] tw_addr_o;

   always #5 clk = ~clk;

   fft_stage_sched #(.N_LOG2(NL), .BF_LATENCY(BF)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (start),
      .inv_i       (inv),
      .hold_i      (hold),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .stage_o     (stage_o),
      .rd_en_o     (rd_en_o),
      .rd_addr_a_o (rd_addr_a_o),
      .rd_addr_b_o (rd_addr_b_o),
      .tw_addr_o   (tw_addr_o),
      .tw_conj_o   (tw_conj_o),
      .wr_en_o     (wr_en_o),
      .wr_addr_a_o (wr_addr_a_o),
      .wr_addr_b_o (wr_addr_b_o)
   );

   int nvec = 0;
   int nbad = 0;

   bit start_p [MAXC];
   bit inv_p   [MAXC];
   bit hold_p  [MAXC];
   bit rst_p   [MAXC];

   int e_rd [MAXC], e_ra [MAXC], e_rb [MAXC], e_tw [MAXC];
   int e_wr [MAXC], e_wa [MAXC], e_wb [MAXC];
   int e_busy [MAXC], e_done [MAXC], e_conj [MAXC], e_stage [MAXC];

   int l_rd [MAXC], l_ra [MAXC], l_rb [MAXC], l_tw [MAXC];
   int l_wa [MAXC], l_wb [MAXC], l_done [MAXC];
   int last_n;

   typedef struct {
      int s; int k; int a; int b; int tw;
   } addr_vec_t;

   function automatic void clear_stim();
      for (int c = 0; c < MAXC; c++) begin
         start_p[c] = 1'b0; inv_p[c] = 1'b0; hold_p[c] = 1'b0; rst_p[c] = 1'b0;
      end
   endfunction

   function automatic void clear_exp(input int from);
      for (int c = from; c < MAXC; c++) begin
         e_rd[c] = 0; e_ra[c] = 0; e_rb[c] = 0; e_tw[c] = 0;
         e_wr[c] = 0; e_wa[c] = 0; e_wb[c] = 0;
         e_busy[c] = 0; e_done[c] = 0; e_conj[c] = 0; e_stage[c] = 0;
      end
   endfunction

   // Schedule model: start accepted in cycle s0, hold_p stalls issue, writes land D cycles after reads
   function automatic int build(input int s0, input int iv);
      int t;
      int span, pos, a;
      t = s0 + 1;
      for (int s = 0; s < NL; s++) begin
         span = 1 << s;
         for (int k = 0; k < HALF; k++) begin
            while (hold_p[t] && t < MAXC - 2 * D - 4) begin
               e_busy[t] = 1; e_stage[t] = s; e_conj[t] = iv;
               t++;
            end
            pos = k % span;
            a   = (k / span) * 2 * span + pos;
            e_rd[t] = 1; e_ra[t] = a; e_rb[t] = a + span; e_tw[t] = pos * (HALF / span);
            e_wr[t + D] = 1; e_wa[t + D] = a; e_wb[t + D] = a + span;
            e_busy[t] = 1; e_stage[t] = s; e_conj[t] = iv;
            t++;
         end
         for (int d = 0; d < D; d++) begin
            e_busy[t] = 1; e_stage[t] = s; e_conj[t] = iv;
            t++;
         end
      end
      e_done[t] = 1;
      e_conj[t] = iv;
      return t;
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      nvec++;
      if (got != exp) begin
         nbad++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; inv = 1'b0; hold = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      @(negedge clk);
      nvec++;
      if ({busy_o, done_o, stage_o, rd_en_o, rd_addr_a_o, rd_addr_b_o, tw_addr_o, tw_conj_o,
           wr_en_o, wr_addr_a_o, wr_addr_b_o} !== '0) begin
         nbad++;
         $display("FAIL reset_outputs got=%b exp=0", {busy_o, done_o, stage_o, rd_en_o,
                  rd_addr_a_o, rd_addr_b_o, tw_addr_o, tw_conj_o, wr_en_o, wr_addr_a_o, wr_addr_b_o});
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic run(input int n, input string tag);
      logic [23:0] gv, ev;
      last_n = n;
      for (int c = 0; c < n; c++) begin
         rst = rst_p[c]; start = start_p[c]; inv = inv_p[c]; hold = hold_p[c];
         @(negedge clk);
         gv = {rd_en_o, rd_addr_a_o, rd_addr_b_o, tw_addr_o, wr_en_o, wr_addr_a_o, wr_addr_b_o,
               busy_o, done_o, tw_conj_o};
         ev = {1'(e_rd[c]), 4'(e_ra[c]), 4'(e_rb[c]), 3'(e_tw[c]), 1'(e_wr[c]), 4'(e_wa[c]),
               4'(e_wb[c]), 1'(e_busy[c]), 1'(e_done[c]), 1'(e_conj[c])};
         nvec++;
         if (gv !== ev) begin
            nbad++;
            $display("FAIL %s cyc%0d {rd,ra,rb,tw,wr,wa,wb,busy,done,conj} got=%h exp=%h",
                     tag, c, gv, ev);
         end
         if (e_busy[c] != 0) begin
            nvec++;
            if (stage_o !== 4'(e_stage[c])) begin
               nbad++;
               $display("FAIL %s_stage cyc%0d got=%0d exp=%0d", tag, c, stage_o, e_stage[c]);
            end
         end
         l_rd[c] = int'(rd_en_o); l_ra[c] = int'(rd_addr_a_o); l_rb[c] = int'(rd_addr_b_o);
         l_tw[c] = int'(tw_addr_o); l_wa[c] = int'(wr_addr_a_o); l_wb[c] = int'(wr_addr_b_o);
         l_done[c] = int'(done_o);
         @(posedge clk); #1;
      end
      rst = 1'b0; start = 1'b0; hold = 1'b0;
   endtask

   // Number of done pulses in the last run, and the cycle of the last one
   task automatic done_stats(output int cnt, output int cyc);
      cnt = 0; cyc = -1;
      for (int c = 0; c < last_n; c++) begin
         if (l_done[c] != 0) begin
            cnt++; cyc = c;
         end
      end
   endtask

   initial begin
      addr_vec_t tbl [6];
      int dc, nd, cd, c;

      tbl[0] = '{s: 0, k: 1, a: 2,  b: 3,  tw: 0};
      tbl[1] = '{s: 1, k: 3, a: 5,  b: 7,  tw: 4};
      tbl[2] = '{s: 3, k: 5, a: 5,  b: 13, tw: 5};
      tbl[3] = '{s: 0, k: 0, a: 0,  b: 1,  tw: 0};
      tbl[4] = '{s: 2, k: 6, a: 10, b: 14, tw: 4};
      tbl[5] = '{s: 3, k: 7, a: 7,  b: 15, tw: 7};

      // Plain transform with a stray start while busy
      do_reset();
      clear_stim(); clear_exp(0);
      start_p[0] = 1'b1; start_p[10] = 1'b1;
      dc = build(0, 0);
      run(dc + 4, "plain");
      done_stats(nd, cd);
      chk("plain_done_count", nd, 1);
      chk("plain_done_cycle", cd, 45);
      for (int i = 0; i < 6; i++) begin
         c = 1 + tbl[i].s * (HALF + 1 + BF) + tbl[i].k;
         chk($sformatf("tbl%0d_rd_a", i), l_ra[c], tbl[i].a);
         chk($sformatf("tbl%0d_rd_b", i), l_rb[c], tbl[i].b);
         chk($sformatf("tbl%0d_tw", i), l_tw[c], tbl[i].tw);
         chk($sformatf("tbl%0d_wr_a", i), l_wa[c + D], tbl[i].a);
         chk($sformatf("tbl%0d_wr_b", i), l_wb[c + D], tbl[i].b);
      end

      // Hold for three cycles in stage 0
      do_reset();
      clear_stim(); clear_exp(0);
      start_p[0] = 1'b1;
      for (int i = 3; i <= 5; i++) hold_p[i] = 1'b1;
      dc = build(0, 0);
      run(dc + 4, "hold3");
      done_stats(nd, cd);
      chk("hold3_done_cycle", cd, 48);
      chk("hold3_resume_a", l_ra[6], 4);

      // Inverse transform with inv toggling afterwards and random hold
      for (int r = 0; r < 3; r++) begin
         do_reset();
         clear_stim(); clear_exp(0);
         start_p[0] = 1'b1;
         inv_p[0] = (r != 1);
         for (int i = 1; i < MAXC; i++) begin
            inv_p[i]  = 1'($urandom_range(0, 1));
            hold_p[i] = ($urandom_range(0, 3) == 0);
         end
         dc = build(0, int'(inv_p[0]));
         run(dc + 4, $sformatf("rand%0d", r));
      end

      // Reset mid-transform, then a fresh transform
      do_reset();
      clear_stim(); clear_exp(0);
      start_p[0] = 1'b1; rst_p[20] = 1'b1; start_p[22] = 1'b1; inv_p[22] = 1'b1;
      dc = build(0, 0);
      clear_exp(21);
      dc = build(22, 1);
      run(dc + 4, "abort");
      done_stats(nd, cd);
      chk("abort_done_count", nd, 1);
      chk("abort_first_rd", l_rd[23], 1);
      chk("abort_first_b", l_rb[23], 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

   // Absolute bound on run time
   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

endmodule

// File: doc/fft_stage_sched.md
Name: fft_stage_sched

Overview:
- In-place radix-2 DIT FFT sequencer: sequences one shared butterfly datapath (complex_mult for the twiddle product, complex_add/complex_sub for the outputs) through all N_LOG2 stages of an N-point transform.
- Issues read address pairs and twiddle addresses to a dual-port sample RAM and twiddle ROM, and issues matching write-back addresses after the fixed datapath latency.
- Sits between the frame loader (input already in bit-reversed order) and the output unloader.
- Carries no sample data.

Parameters:
- N_LOG2, 4, log2 of transform length N (N = 2^N_LOG2, N >= 4).
- BF_LATENCY, 2, cycles from RAM read data valid to butterfly result valid (>= 1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a transform; sampled only in IDLE.
- inv  in  1  inverse-transform select; captured when start is accepted.
- hold  in  1  suppresses read issue while high (back-pressure from RAM arbiter).
- busy  out  1  high from the first issue cycle through the final write cycle.
- done  out  1  one-cycle pulse in the cycle after the final write.
- stage  out  N_LOG2 bits  current issue stage index (0..N_LOG2-1).
- rd_en  out  1  read pair valid this cycle.
- rd_addr_a  out  N_LOG2  upper butterfly input address.
- rd_addr_b  out  N_LOG2  lower butterfly input address.
- tw_addr  out  N_LOG2-1  twiddle ROM index, aligned with rd_en.
- tw_conj  out  1  = captured inv; datapath conjugates the twiddle when high.
- wr_en  out  1  write-back pair valid this cycle.
- wr_addr_a  out  N_LOG2  write address for the sum output.
- wr_addr_b  out  N_LOG2  write address for the difference output.

Behaviour:
- Reset: every output is 0, FSM is in IDLE, and the delay line is cleared. Reset asserted mid-transform aborts immediately: no further rd_en/wr_en and no done pulse.
- FSM states: IDLE, ISSUE, DRAIN, FIN.
  - IDLE: start=1 captures inv, sets stage=0 and k=0, then moves to ISSUE.
  - ISSUE: in each cycle with hold=0, assert rd_en with the addresses for (stage, k) and increment k.
    - When hold=1: rd_en=0 and k is held.
    - After k = N/2-1 is issued, move to DRAIN with the drain counter set to 1+BF_LATENCY.
  - DRAIN: decrement the counter each cycle. At 0: if stage = N_LOG2-1, go to FIN; otherwise stage+1, k=0, go to ISSUE.
  - FIN: done=1 for one cycle, then IDLE.
- start outside IDLE is ignored.
- Address generation for stage s and butterfly index k (0..N/2-1):
  - span = 2^s, pos = k mod span, grp = k >> s.
  - a = grp*2*span + pos, b = a + span.
  - tw = pos << (N_LOG2-1-s).
  - All values are unsigned and fit their widths; no wrap is possible.
- Write path: a shift register of depth 1+BF_LATENCY carries {rd_en, a, b}. Its output drives wr_en, wr_addr_a and wr_addr_b, so a write appears exactly 1+BF_LATENCY cycles after its read (1 RAM cycle plus datapath).
- Bubbles caused by hold propagate as wr_en=0.
- The delay line advances every cycle in every state; hold does not stall it.
- DRAIN guarantees the last write of stage s occurs before the first read of stage s+1 (no RAW hazard): the first issue of stage s+1 follows the last write of stage s by exactly one cycle.
- busy = (state is ISSUE or DRAIN).
- Timing with hold=0 and start in cycle 0:
  - Stage s issues in cycles 1+s*(N/2+1+BF_LATENCY) onward.
  - Total busy cycles = N_LOG2*(N/2+1+BF_LATENCY).

Decomposition:
- Shared package fft_ctrl_pkg holds:
  - FSM state encoding (IDLE/ISSUE/DRAIN/FIN).
  - Derived constants N and HALF_N, and the counter widths.
- One natural sub-module: fft_addr_gen, combinational. It maps (stage, k) to (a, b, tw) and is reusable by the unloader's bit-reverse logic.
- The delay line stays inline.

Test Plan:
- N_LOG2=4, BF_LATENCY=2, start in cycle 0, hold=0:
  - rd_en high in cycles 1-8, 12-19, 23-30, 34-41.
  - busy high in cycles 1-44; last wr_en in cycle 44; done pulses only in cycle 45.
- Address check (N=16):
  - stage0 k=1 -> a=2, b=3, tw=0.
  - stage1 k=3 -> a=5, b=7, tw=4.
  - stage3 k=5 -> a=5, b=13, tw=5.
  - Each pair reappears on wr_addr_a/b exactly 3 cycles later.
- hold=1 for cycles 3-5 in stage 0:
  - rd_en low in cycles 3-5 and k resumes at 2; wr_en low in cycles 6-8.
  - Total transform is 3 cycles longer: done in cycle 48.
- start asserted again in cycle 10 while busy -> ignored; exactly one done pulse (cycle 45).
- rst asserted in cycle 20 -> from cycle 21 all outputs are 0 and the FSM is in IDLE. A new start in cycle 22 yields a clean full transform, with first rd_en in cycle 23 (a=0, b=1).
- inv=1 at start, then inv toggled mid-transform -> tw_conj stays 1 until done, then returns to 0 in IDLE.
